// File: rtl/lea_block_xor_seq.sv
// lea_block_xor_seq: sequential LEA key-mixing engine.
// XORs an NWORDS-word block with a same-width round key, LANES words per
// cycle, between a valid/ready input handshake and a valid/ready output
// handshake. One block is in flight at a time.
// Optional build macro: LEA_XOR_ZEROIZE_EN clears the work and key registers
// on the output handshake so no key material lingers once a result is taken.
module lea_block_xor_seq #(
    parameter int WORD_W = 32,
    parameter int NWORDS = 4,
    parameter int LANES  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NWORDS*WORD_W-1:0] block_in,
    input  logic [NWORDS*WORD_W-1:0] key_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NWORDS*WORD_W-1:0] result,
    output logic                     busy
);

    localparam int BLK_W   = NWORDS * WORD_W;
    localparam int NGROUPS = NWORDS / LANES;
    localparam int CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NGROUPS - 1);

    // Lanes must tile the block exactly; otherwise the last group would be ragged.
    generate
        if ((LANES < 1) || (NWORDS % LANES != 0)) begin : g_bad_lanes
            $error("lea_block_xor_seq: NWORDS must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BLK_W-1:0]   work_q, work_d;
    logic [BLK_W-1:0]   key_q, key_d;
    logic [BLK_W-1:0]   work_xor;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Per-word candidate: words in the group selected by the counter get the
    // key XORed in, every other word passes through unchanged.
    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
            localparam logic [CNT_W-1:0] GRP = CNT_W'(gi / LANES);
            assign work_xor[gi*WORD_W +: WORD_W] =
                (cnt_q == GRP) ? (work_q[gi*WORD_W +: WORD_W] ^ key_q[gi*WORD_W +: WORD_W])
                               : work_q[gi*WORD_W +: WORD_W];
        end
    endgenerate

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        key_d     = key_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    work_d  = block_in;
                    key_d   = key_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                work_d = work_xor;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
`ifdef LEA_XOR_ZEROIZE_EN
                    work_d  = '0;
                    key_d   = '0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
        end
    end

    // The work register is only complete in DONE; out_valid qualifies it.
    assign result = work_q;

endmodule

// File: tb/tb_lea_block_xor_seq.sv
// Directed bench for lea_block_xor_seq: a LANES=1 instance and a LANES=4
// instance share clock and reset; expected values are hand-computed.
module tb_lea_block_xor_seq;

    localparam logic [127:0] B1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] K1 = 128'hFFFFFFFF_00000000_0F0F0F0F_12345678;
    localparam logic [127:0] R1 = 128'hFFEEDDCC_44556677_8796A5B4_DEE9B887;
    localparam logic [127:0] BA = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
    localparam logic [127:0] KA = 128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A;
    localparam logic [127:0] RA = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;

    logic         clk;
    logic         rst_n;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [127:0] a_block, a_key, a_result;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [127:0] b_block, b_key, b_result;

    int n_total;
    int n_bad;
    int lat;

    lea_block_xor_seq #(.WORD_W(32), .NWORDS(4), .LANES(1)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .block_in  (a_block),
        .key_in    (a_key),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .result    (a_result),
        .busy      (a_busy)
    );

    lea_block_xor_seq #(.WORD_W(32), .NWORDS(4), .LANES(4)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .block_in  (b_block),
        .key_in    (b_key),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .result    (b_result),
        .busy      (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until the chosen instance raises out_valid (bounded).
    task automatic wait_valid(input bit sel_b, output int cycles);
        cycles = 0;
        while (((sel_b ? b_out_valid : a_out_valid) !== 1'b1) && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        a_in_valid = 0; a_out_ready = 0; a_block = '0; a_key = '0;
        b_in_valid = 0; b_out_ready = 0; b_block = '0; b_key = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        check("rst_a_in_ready",  a_in_ready,  1);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_busy",      a_busy,      0);
        check("rst_a_result",    a_result,    '0);
        check("rst_b_in_ready",  b_in_ready,  1);
        check("rst_b_result",    b_result,    '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Test 1: basic XOR, LANES=1
        a_block = B1; a_key = K1; a_in_valid = 1; a_out_ready = 1;
        tick();
        a_in_valid = 0;
        check("t1_run_in_ready", a_in_ready, 0);
        check("t1_run_busy",     a_busy,     1);
        wait_valid(0, lat);
        check("t1_latency", lat, 4);
        check("t1_result",  a_result, R1);
        tick();
        check("t1_out_valid_drop", a_out_valid, 0);
        check("t1_in_ready_back",  a_in_ready,  1);
`ifdef LEA_XOR_ZEROIZE_EN
        check("t6_zeroize_result", a_result, '0);
`else
        check("t6_hold_result",    a_result, R1);
`endif

        // Test 2: backpressure, then test 3 (involution) accepted after handshake
        a_out_ready = 0; a_block = B1; a_key = K1; a_in_valid = 1;
        tick();
        a_in_valid = 0;
        wait_valid(0, lat);
        check("t2_latency", lat, 4);
        a_block = R1; a_in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_hold_result_%0d", i),   a_result,    R1);
            check($sformatf("t2_hold_in_ready_%0d", i), a_in_ready,  0);
            check($sformatf("t2_hold_busy_%0d", i),     a_busy,      1);
            check($sformatf("t2_hold_valid_%0d", i),    a_out_valid, 1);
            tick();
        end
        a_out_ready = 1;
        tick();
        check("t2_post_hs_valid",    a_out_valid, 0);
        check("t2_post_hs_in_ready", a_in_ready,  1);
        tick();
        a_in_valid = 0;
        check("t3_accepted_in_ready", a_in_ready, 0);
        wait_valid(0, lat);
        check("t3_latency", lat, 4);
        check("t3_result",  a_result, B1);
        tick();
        check("t3_out_valid_drop", a_out_valid, 0);

        // Test 4: LANES=4 instance, single-cycle processing
        b_block = BA; b_key = KA; b_in_valid = 1; b_out_ready = 1;
        tick();
        b_in_valid = 0;
        check("t4_busy", b_busy, 1);
        wait_valid(1, lat);
        check("t4_latency", lat, 1);
        check("t4_result",  b_result, RA);
        tick();
        check("t4_out_valid_drop", b_out_valid, 0);
`ifdef LEA_XOR_ZEROIZE_EN
        check("t4_zeroize_result", b_result, '0);
`else
        check("t4_hold_result",    b_result, RA);
`endif

        // Test 5: reset two cycles after accept
        a_block = B1; a_key = K1; a_in_valid = 1; a_out_ready = 1;
        tick();
        a_in_valid = 0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", a_out_valid, 0);
        check("t5_rst_busy",      a_busy,      0);
        check("t5_rst_result",    a_result,    '0);
        check("t5_rst_in_ready",  a_in_ready,  1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("t5_rel_busy",   a_busy,   0);
        check("t5_rel_result", a_result, '0);
        a_in_valid = 1;
        tick();
        a_in_valid = 0;
        wait_valid(0, lat);
        check("t5_next_latency", lat, 4);
        check("t5_next_result",  a_result, R1);
        tick();
        check("t5_next_valid_drop", a_out_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
